// File: rtl/beamformer_pkg.sv
// Shared beamformer definitions: default output-stage geometry, the stereo PCM
// pair type, and the serializer state encoding.
package beamformer_pkg;

  localparam int OUT_WIDTH  = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] left;
    logic [OUT_WIDTH-1:0] right;
  } pcm_pair_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } ser_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy count. Pushes when full and pops when empty
// are ignored, so callers may present requests unconditionally.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define validity, and a resettable array would cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/i2s_pcm_serializer.sv
// Beamformer output stage: saturates summed stereo samples, queues them, and
// streams Philips-I2S frames with a self-generated word select.
module i2s_pcm_serializer #(
  parameter int IN_WIDTH   = 20,
  parameter int OUT_WIDTH  = beamformer_pkg::OUT_WIDTH,
  parameter int SLOT_BITS  = beamformer_pkg::SLOT_BITS,
  parameter int FIFO_DEPTH = beamformer_pkg::FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_WIDTH-1:0]         in_left,
  input  logic [IN_WIDTH-1:0]         in_right,
  input  logic                        clear_flags,
  output logic                        ws,
  output logic                        sd,
  output logic                        frame_start,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        clipped,
  output logic                        underrun
);

  import beamformer_pkg::*;

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);

  // Returns {clipped, word}: in range when the bits above the output sign all
  // match it; otherwise clamp toward the input's sign.
  function automatic logic [OUT_WIDTH:0] saturate(input logic [IN_WIDTH-1:0] x);
    logic [IN_WIDTH-OUT_WIDTH:0] head;
    head = x[IN_WIDTH-1:OUT_WIDTH-1];
    if (&head || ~|head) return {1'b0, x[OUT_WIDTH-1:0]};
    else if (x[IN_WIDTH-1]) return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    else return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
  endfunction

  logic [CW-1:0]           r_cnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic                    r_sd;
  logic                    r_clipped;
  logic                    r_underrun;
  ser_state_t              r_state;
  ser_state_t              w_state_next;
  logic [OUT_WIDTH:0]      w_sat_l;
  logic [OUT_WIDTH:0]      w_sat_r;
  logic [2*OUT_WIDTH-1:0]  w_rdata;
  logic [FRAME_BITS-1:0]   w_frame;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_frame_edge;
  logic                    w_clip_set;
  logic                    w_underrun_set;

  assign w_sat_l      = saturate(in_left);
  assign w_sat_r      = saturate(in_right);
  assign w_frame_edge = (r_cnt == '0);
  assign w_push       = in_valid && !w_full;
  assign w_pop        = w_frame_edge && !w_empty;
  assign w_clip_set   = w_push && (w_sat_l[OUT_WIDTH] || w_sat_r[OUT_WIDTH]);

  sample_fifo #(
    .WIDTH (2 * OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({w_sat_l[OUT_WIDTH-1:0], w_sat_r[OUT_WIDTH-1:0]}),
    .o_rdata (w_rdata),
    .o_count (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Left word left-justified in the first slot, right word in the second.
  always_comb begin
    w_frame = '0;
    if (w_pop) begin
      w_frame[FRAME_BITS-1 -: OUT_WIDTH] = w_rdata[2*OUT_WIDTH-1 -: OUT_WIDTH];
      w_frame[SLOT_BITS-1 -: OUT_WIDTH]  = w_rdata[OUT_WIDTH-1:0];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    w_underrun_set = 1'b0;
    case (r_state)
      ST_IDLE: if (w_pop) w_state_next = ST_RUN;
      ST_RUN:  w_underrun_set = w_frame_edge && w_empty;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_clipped  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= (r_cnt == CW'(FRAME_BITS - 1)) ? '0 : r_cnt + 1'b1;
      r_clipped  <= w_clip_set | (r_clipped & ~clear_flags);
      r_underrun <= w_underrun_set | (r_underrun & ~clear_flags);
    end
  end

  // The one-bit I2S delay falls out of registering sd: the bit chosen during
  // cnt == c appears during cnt == c+1, so the frame MSB lands in cnt == 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_sd    <= 1'b0;
    end else if (w_frame_edge) begin
      r_sd    <= w_frame[FRAME_BITS-1];
      r_shift <= w_frame << 1;
    end else begin
      r_sd    <= r_shift[FRAME_BITS-1];
      r_shift <= r_shift << 1;
    end
  end

  assign in_ready    = !w_full;
  assign ws          = (r_cnt >= CW'(SLOT_BITS));
  assign frame_start = w_frame_edge;
  assign sd          = r_sd;
  assign clipped     = r_clipped;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_pcm_serializer.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a frame-level reference model of the I2S output stage.
module tb_i2s_pcm_serializer;

  import beamformer_pkg::*;

  localparam int IW   = 20;
  localparam int FB   = 2 * SLOT_BITS;
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int MAXV = 2 ** (OUT_WIDTH - 1) - 1;
  localparam int MINV = -(2 ** (OUT_WIDTH - 1));

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_left;
  logic [IW-1:0] in_right;
  logic          clear_flags;
  logic          ws;
  logic          sd;
  logic          frame_start;
  logic [LW-1:0] fifo_level;
  logic          clipped;
  logic          underrun;

  always #5 clk = ~clk;

  i2s_pcm_serializer #(
    .IN_WIDTH   (IW),
    .OUT_WIDTH  (OUT_WIDTH),
    .SLOT_BITS  (SLOT_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_left     (in_left),
    .in_right    (in_right),
    .clear_flags (clear_flags),
    .ws          (ws),
    .sd          (sd),
    .frame_start (frame_start),
    .fifo_level  (fifo_level),
    .clipped     (clipped),
    .underrun    (underrun)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: cnt value shown this cycle, queued pairs, frame on the wire.
  int            m_cnt;
  pcm_pair_t     m_q[$];
  bit            m_run;
  bit            m_clipped;
  bit            m_underrun;
  bit            m_accepted;
  logic [FB-1:0] m_frame;

  function automatic int clamp(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at t=%0t cnt=%0d: observed %0h expected %0h", tag, $time, m_cnt, obs, exp);
  endtask

  task automatic model_edge();
    int        sz;
    int        lv;
    int        rv;
    bit        clip_set;
    bit        ur_set;
    pcm_pair_t p;
    if (reset) begin
      m_cnt = 0; m_q.delete(); m_run = 0; m_clipped = 0; m_underrun = 0;
      m_frame = '0; m_accepted = 0;
      return;
    end
    sz = m_q.size();
    clip_set = 0;
    ur_set = 0;
    m_accepted = in_valid && (sz < FIFO_DEPTH);
    if (m_cnt == 0) begin
      if (sz > 0) begin
        p = m_q.pop_front();
        m_frame = (FB'(p.left) << (FB - OUT_WIDTH)) | (FB'(p.right) << (SLOT_BITS - OUT_WIDTH));
        m_run = 1;
      end else begin
        m_frame = '0;
        ur_set = m_run;
      end
    end
    if (m_accepted) begin
      lv = int'($signed(in_left));
      rv = int'($signed(in_right));
      p.left  = OUT_WIDTH'(clamp(lv));
      p.right = OUT_WIDTH'(clamp(rv));
      clip_set = (clamp(lv) != lv) || (clamp(rv) != rv);
      m_q.push_back(p);
    end
    m_clipped  = clip_set || (m_clipped && !clear_flags);
    m_underrun = ur_set || (m_underrun && !clear_flags);
    m_cnt = (m_cnt + 1) % FB;
  endtask

  task automatic check_outputs();
    logic exp_sd;
    exp_sd = (m_cnt == 0) ? m_frame[0] : m_frame[FB - m_cnt];
    check("sd", 32'(sd), 32'(exp_sd));
    check("ws", 32'(ws), 32'(m_cnt >= SLOT_BITS));
    check("frame_start", 32'(frame_start), 32'(m_cnt == 0));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("in_ready", 32'(in_ready), 32'(m_q.size() < FIFO_DEPTH));
    check("clipped", 32'(clipped), 32'(m_clipped));
    check("underrun", 32'(underrun), 32'(m_underrun));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_cnt(input int c);
    for (int i = 0; i < FB && m_cnt != c; i++) step();
  endtask

  task automatic push_pair(input logic [IW-1:0] l, input logic [IW-1:0] r);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    for (int i = 0; i < 4 * FB && !done; i++) begin
      step();
      done = m_accepted;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_total++;
      $error("FAIL push_timeout at t=%0t: observed not accepted expected accepted", $time);
    end
  endtask

  function automatic logic [IW-1:0] rand_sample();
    logic [15:0] s;
    if ($urandom_range(0, 3) == 0) return IW'($urandom);
    s = 16'($urandom);
    return {{(IW - 16){s[15]}}, s};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; clear_flags = 1'b0;
    in_left = '0; in_right = '0;
    @(negedge clk);

    // 1: plain pair, no clipping
    do_reset();
    check("rst_frame_start", 32'(frame_start), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    push_pair(20'h01234, 20'hFFFFF);
    run(2 * FB);

    // 2: overflow/underflow saturate, then clear_flags
    push_pair(20'h40000, 20'h80000);
    check("clip_next_cycle", 32'(clipped), 32'd1);
    run(10);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("clip_cleared", 32'(clipped), 32'd0);
    run(2 * FB);

    // 3: five back-to-back pairs starting at cnt 2
    wait_cnt(2);
    for (int k = 0; k < 4; k++) push_pair(rand_sample(), rand_sample());
    check("full_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check("full_not_ready", 32'(in_ready), 32'd0);
    push_pair(rand_sample(), rand_sample());
    check("refill_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    run(6 * FB);

    // 4: idle frames are silent; underrun only after first pop
    do_reset();
    run(3 * FB);
    check("idle_no_underrun", 32'(underrun), 32'd0);
    push_pair(20'h0ABCD, 20'hF1234);
    run(3 * FB);

    // 5: mid-frame reset with two pairs queued
    wait_cnt(1);
    push_pair(20'h05555, 20'h0AAAA);
    push_pair(20'h03333, 20'h0CCCC);
    wait_cnt(20);
    do_reset();
    check("rst_mid_ws", 32'(ws), 32'd0);
    check("rst_mid_sd", 32'(sd), 32'd0);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    check("rst_mid_underrun", 32'(underrun), 32'd0);
    run(2 * FB);

    // 6: push into empty FIFO exactly at cnt 0 while running
    push_pair(20'h00F0F, 20'h0F0F0);
    run(FB + 4);
    wait_cnt(0);
    push_pair(20'h07E7E, 20'hF8181);
    check("push_at_0_underrun", 32'(underrun), 32'd1);
    run(3 * FB);

    // 7: randomized traffic with occasional clears and one reset
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      if (!in_valid || m_accepted) begin
        in_valid = ($urandom_range(0, 99) < ((i < 2000) ? 4 : 1));
        in_left  = rand_sample();
        in_right = rand_sample();
      end
      clear_flags = ($urandom_range(0, 99) < 2);
      step();
    end
    in_valid = 1'b0;
    clear_flags = 1'b0;
    run(FIFO_DEPTH * FB + FB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
